// File: rtl/itch_packet_rx_if.sv
// Beat-stream bundle between the MAC-side driver and itch_packet_rx.
// Optional byte-count signal present when ITCH_RX_BYTE_CNT_EN is defined.
interface itch_packet_rx_if #(
    parameter int DATA_W    = 64,
    parameter int LEN_W     = 3,
    parameter int CNT_W     = 7,
    parameter int PKT_CNT_W = 16
);
    logic [DATA_W-1:0]    rx_data_net;
    logic                 rx_sof_net;
    logic                 rx_eof_net;
    logic [LEN_W-1:0]     rx_len_net;
    logic                 rx_vld_net;

    logic [DATA_W-1:0]    out_data;
    logic                 out_vld;
    logic                 out_sof;
    logic                 out_eof;
    logic [DATA_W/8-1:0]  out_keep;
    logic [CNT_W-1:0]     beat_cnt;
    logic [PKT_CNT_W-1:0] pkt_cnt;
    logic                 err_orphan;
    logic                 err_restart;
`ifdef ITCH_RX_BYTE_CNT_EN
    logic [CNT_W+LEN_W-1:0] last_pkt_bytes;
`endif

    modport master (
        output rx_data_net, rx_sof_net, rx_eof_net, rx_len_net, rx_vld_net,
        input  out_data, out_vld, out_sof, out_eof, out_keep,
               beat_cnt, pkt_cnt, err_orphan, err_restart
`ifdef ITCH_RX_BYTE_CNT_EN
        , input last_pkt_bytes
`endif
    );

    modport slave (
        input  rx_data_net, rx_sof_net, rx_eof_net, rx_len_net, rx_vld_net,
        output out_data, out_vld, out_sof, out_eof, out_keep,
               beat_cnt, pkt_cnt, err_orphan, err_restart
`ifdef ITCH_RX_BYTE_CNT_EN
        , output last_pkt_bytes
`endif
    );
endinterface

// File: rtl/itch_packet_rx.sv
// ITCH packet receive front-end: framing FSM, last-beat byte masking, beat/packet counters.
// Define ITCH_RX_BYTE_CNT_EN to add the last_pkt_bytes output.
module itch_packet_rx #(
    parameter int DATA_W    = 64,
    parameter int LEN_W     = 3,
    parameter int CNT_W     = 7,
    parameter int PKT_CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    itch_packet_rx_if.slave   bus
);
    localparam int KEEP_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t               state_q;
    logic [DATA_W-1:0]    data_q,  data_d;
    logic [KEEP_W-1:0]    keep_q,  keep_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q;
    logic                 vld_q, sof_q, eof_q, orphan_q, restart_q;
    logic                 start, cont, emit, done, orphan, restart;
`ifdef ITCH_RX_BYTE_CNT_EN
    logic [CNT_W+LEN_W-1:0] bytes_q, bytes_d;
    logic                   sat;
`endif

    always_comb begin
        start   = bus.rx_vld_net & bus.rx_sof_net;
        cont    = bus.rx_vld_net & ~bus.rx_sof_net & (state_q == IN_PKT);
        orphan  = bus.rx_vld_net & ~bus.rx_sof_net & (state_q == IDLE);
        restart = start & (state_q == IN_PKT);
        emit    = start | cont;
        done    = emit & bus.rx_eof_net;

        keep_d = '1;
        data_d = bus.rx_data_net;
        for (int b = 0; b < KEEP_W; b++) begin
            keep_d[b] = ~bus.rx_eof_net | (b <= int'(bus.rx_len_net));
            if (!keep_d[b]) data_d[b*8 +: 8] = 8'h00;
        end

        if (start)                    beat_cnt_d = CNT_W'(1);
        else if (beat_cnt_q == CNT_MAX) beat_cnt_d = CNT_MAX;
        else                          beat_cnt_d = beat_cnt_q + CNT_W'(1);

`ifdef ITCH_RX_BYTE_CNT_EN
        // Saturated means the true beat count has run past what beat_cnt can hold.
        sat     = cont & (beat_cnt_q == CNT_MAX);
        bytes_d = {beat_cnt_d - CNT_W'(1), LEN_W'(0)}
                + (CNT_W+LEN_W)'(bus.rx_len_net) + (CNT_W+LEN_W)'(1);
        if (sat) bytes_d = '1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            keep_q     <= '0;
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            vld_q      <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            orphan_q   <= 1'b0;
            restart_q  <= 1'b0;
`ifdef ITCH_RX_BYTE_CNT_EN
            bytes_q    <= '0;
`endif
        end else begin
            vld_q     <= emit;
            sof_q     <= start;
            eof_q     <= done;
            orphan_q  <= orphan;
            restart_q <= restart;
            if (emit) begin
                data_q     <= data_d;
                keep_q     <= keep_d;
                beat_cnt_q <= beat_cnt_d;
            end
            if (done) begin
                pkt_cnt_q <= pkt_cnt_q + PKT_CNT_W'(1);
`ifdef ITCH_RX_BYTE_CNT_EN
                bytes_q   <= bytes_d;
`endif
            end
            // A restart re-enters exactly like a fresh sof from IDLE.
            if (start)     state_q <= bus.rx_eof_net ? IDLE : IN_PKT;
            else if (done) state_q <= IDLE;
        end
    end

    assign bus.out_data    = data_q;
    assign bus.out_keep    = keep_q;
    assign bus.out_vld     = vld_q;
    assign bus.out_sof     = sof_q;
    assign bus.out_eof     = eof_q;
    assign bus.beat_cnt    = beat_cnt_q;
    assign bus.pkt_cnt     = pkt_cnt_q;
    assign bus.err_orphan  = orphan_q;
    assign bus.err_restart = restart_q;
`ifdef ITCH_RX_BYTE_CNT_EN
    assign bus.last_pkt_bytes = bytes_q;
`endif
endmodule
